// File: rtl/stage_4_mem.sv
// Pipeline stage 4: data-memory access with byte-lane steering, load extension and access timeout.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of forcing alignment.
module stage_4_mem #(
  parameter int unsigned WAIT_LIMIT = 32'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_idx,
  input  logic [2:0]  mem_size,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic        reg_write_enable,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] wb_val,
  output logic [4:0]  rd_idx_out,
  output logic        reg_write_enable_out,
  output logic        bus_err_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_out
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic        rwe_q, rwe_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [31:0] wb_q, wb_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        rwe_out_q, rwe_out_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic        is_mem_s;
  logic        mis_s;
  logic        timeout_s;

  // Byte enables; size[1:0]: 0=B, 1=H, other=W (H ignores o[0], W always lane 0).
  function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] o);
    logic [3:0] be;
    case (size[1:0])
      2'b00:   be = 4'b0001 << o;
      2'b01:   be = 4'b0011 << {o[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [2:0] size, input logic [31:0] rs2);
    logic [31:0] wd;
    case (size[1:0])
      2'b00:   wd = {4{rs2[7:0]}};
      2'b01:   wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

  // size[2] selects zero extension (BU/HU); W passes the word through untouched.
  function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] o,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    case (size[1:0])
      2'b00: begin
        sh  = rdata >> {o, 3'b000};
        res = size[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = rdata >> {o[1], 4'b0000};
        res = size[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: begin
        sh  = rdata;
        res = sh;
      end
    endcase
    return res;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] o);
    logic m;
    case (size[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = o[0];
      default: m = (o != 2'b00);
    endcase
    return m;
  endfunction

  assign mis_s = valid_in && is_mem_s && is_misaligned(mem_size, alu_res[1:0]);
  assign misaligned_out = mis_q;
`else
  assign mis_s = 1'b0;
`endif

  assign is_mem_s  = mem_read_enable || mem_write_enable;
  assign timeout_s = (WAIT_LIMIT != 32'd0) && (state_q == S_REQ) && !dmem_ready &&
                     (wait_cnt_q == (WAIT_LIMIT - 32'd1));

  assign stall_out            = (state_q == S_REQ);
  assign dmem_req             = (state_q == S_REQ);
  assign dmem_we              = store_q;
  assign dmem_addr            = {addr_q[31:2], 2'b00};
  assign dmem_wdata           = wdata_q;
  assign dmem_be              = be_q;
  assign valid_out            = valid_q;
  assign wb_val               = wb_q;
  assign rd_idx_out           = rd_out_q;
  assign reg_write_enable_out = rwe_out_q;
  assign bus_err_out          = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in && is_mem_s && !mis_s) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dmem_ready || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    store_d    = store_q;
    rd_d       = rd_q;
    rwe_d      = rwe_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    valid_d    = 1'b0;
    wb_d       = wb_q;
    rd_out_d   = rd_out_q;
    rwe_out_d  = rwe_out_q;
    err_d      = 1'b0;
    mis_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_cnt_d = 32'd0;
        if (!valid_in) begin
          valid_d = 1'b0;
        end else if (!is_mem_s) begin
          valid_d   = 1'b1;
          wb_d      = alu_res;
          rd_out_d  = rd_idx;
          rwe_out_d = reg_write_enable && (rd_idx != 5'd0);
        end else if (mis_s) begin
          valid_d   = 1'b1;
          rd_out_d  = rd_idx;
          rwe_out_d = 1'b0;
          mis_d     = 1'b1;
        end else begin
          addr_d  = alu_res;
          size_d  = mem_size;
          store_d = mem_write_enable;
          rd_d    = rd_idx;
          rwe_d   = reg_write_enable && !mem_write_enable && (rd_idx != 5'd0);
          be_d    = calc_be(mem_size, alu_res[1:0]);
          wdata_d = calc_wdata(mem_size, rs2_val);
        end
      end
      S_REQ: begin
        if (dmem_ready) begin
          wait_cnt_d = 32'd0;
          valid_d    = 1'b1;
          wb_d       = store_q ? addr_q : load_ext(size_q, addr_q[1:0], dmem_rdata);
          rd_out_d   = rd_q;
          rwe_out_d  = rwe_q;
        end else if (timeout_s) begin
          wait_cnt_d = 32'd0;
          valid_d    = 1'b1;
          rd_out_d   = rd_q;
          rwe_out_d  = 1'b0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      default: begin
        wait_cnt_d = 32'd0;
      end
    endcase
  end

  // Latched access and registered writeback outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 32'd0;
      addr_q     <= 32'd0;
      size_q     <= 3'd0;
      store_q    <= 1'b0;
      rd_q       <= 5'd0;
      rwe_q      <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      valid_q    <= 1'b0;
      wb_q       <= 32'd0;
      rd_out_q   <= 5'd0;
      rwe_out_q  <= 1'b0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      rwe_q      <= rwe_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      wb_q       <= wb_d;
      rd_out_q   <= rd_out_d;
      rwe_out_q  <= rwe_out_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
    end
  end

endmodule

// File: tb/tb_stage_4_mem.sv
// Scoreboard bench for stage_4_mem: writebacks are queued at issue and checked when valid_out rises.
module tb_stage_4_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_res;
  logic [31:0] rs2_val;
  logic [4:0]  rd_idx;
  logic [2:0]  mem_size;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        reg_write_enable;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [31:0] wb_val;
  logic [4:0]  rd_idx_out;
  logic        reg_write_enable_out;
  logic        bus_err_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned_out;
`endif

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rwe;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  stage_4_mem #(.WAIT_LIMIT(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .valid_in             (valid_in),
    .alu_res              (alu_res),
    .rs2_val              (rs2_val),
    .rd_idx               (rd_idx),
    .mem_size             (mem_size),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .reg_write_enable     (reg_write_enable),
    .stall_out            (stall_out),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_be              (dmem_be),
    .dmem_ready           (dmem_ready),
    .dmem_rdata           (dmem_rdata),
    .valid_out            (valid_out),
    .wb_val               (wb_val),
    .rd_idx_out           (rd_idx_out),
    .reg_write_enable_out (reg_write_enable_out),
    .bus_err_out          (bus_err_out)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misaligned_out       (misaligned_out)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every valid_out must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      exp_t e;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: valid_out=1 with wb_val=%h but nothing expected", wb_val);
      end else begin
        e = sb.pop_front();
        if (e.chk_data && (wb_val !== e.wb || rd_idx_out !== e.rd)) begin
          n_err++;
          $display("FAIL sb_data: got wb=%h rd=%0d want wb=%h rd=%0d", wb_val, rd_idx_out, e.wb, e.rd);
        end
        n_vec++;
        if (reg_write_enable_out !== e.rwe || bus_err_out !== e.err) begin
          n_err++;
          $display("FAIL sb_ctrl: got rwe=%b err=%b want rwe=%b err=%b",
                   reg_write_enable_out, bus_err_out, e.rwe, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in         = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    reg_write_enable = 1'b0;
    alu_res          = 32'hFFFF_FFFF;
    rs2_val          = 32'h0000_0000;
    rd_idx           = 5'd31;
    mem_size         = 3'd2;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    repeat (3) tick();
    chk("reset_ctrl", {31'd0, stall_out, dmem_req, dmem_we, valid_out, reg_write_enable_out, bus_err_out},
        32'd0);
    chk("reset_wb", wb_val, 32'd0);
    chk("reset_rd", {27'd0, rd_idx_out}, 32'd0);
    chk("reset_bus", dmem_addr | dmem_wdata | {28'd0, dmem_be}, 32'd0);
    reset = 1'b0;
    tick();
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [4:0] rd, input logic rwe, input logic exp_rwe);
    valid_in         = 1'b1;
    alu_res          = a;
    rd_idx           = rd;
    reg_write_enable = rwe;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    sb.push_back('{a, rd, exp_rwe, 1'b0, 1'b1});
    tick();
    chk("alu_valid", {31'd0, valid_out}, 32'd1);
    chk("alu_stall", {31'd0, stall_out}, 32'd0);
  endtask

  task automatic test_alu();
    alu_op(32'h0000_1234, 5'd5, 1'b1, 1'b1);
    alu_op(32'hDEAD_0001, 5'd0, 1'b1, 1'b0);
    alu_op(32'h0BAD_F00D, 5'd12, 1'b0, 1'b0);
    idle_inputs();
    tick();
    chk("alu_idle_valid", {31'd0, valid_out}, 32'd0);
    chk("alu_hold_wb", wb_val, 32'h0BAD_F00D);
  endtask

  task automatic mem_op(input string nm, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [2:0] size, input logic rden, input logic wren,
                        input logic [4:0] rd, input logic rwe, input logic [31:0] rdata,
                        input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input logic exp_rwe);
    valid_in         = 1'b1;
    alu_res          = addr;
    rs2_val          = rs2;
    mem_size         = size;
    mem_read_enable  = rden;
    mem_write_enable = wren;
    rd_idx           = rd;
    reg_write_enable = rwe;
    sb.push_back('{exp_wb, rd, exp_rwe, 1'b0, 1'b1});
    tick();
    idle_inputs();
    for (int i = 0; i <= waits; i++) begin
      chk({nm, "_req"}, {30'd0, dmem_req, stall_out}, 32'd3);
      chk({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({nm, "_be_we"}, {27'd0, dmem_be, dmem_we}, {27'd0, exp_be, wren});
      if (wren) begin
        chk({nm, "_wdata"}, dmem_wdata, exp_wdata);
      end
      if (i == waits) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end
      tick();
      dmem_ready = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
    end
    chk({nm, "_done"}, {30'd0, stall_out, valid_out}, 32'd1);
  endtask

  task automatic test_loads_stores();
    mem_op("lb", 32'h0000_0103, 32'd0, 3'd0, 1'b1, 1'b0, 5'd7, 1'b1, 32'h80FF_0000, 2,
           4'b1000, 32'd0, 32'hFFFF_FF80, 1'b1);
    mem_op("sh", 32'h0000_0102, 32'hABCD_5678, 3'd1, 1'b0, 1'b1, 5'd8, 1'b1, 32'd0, 0,
           4'b1100, 32'h5678_5678, 32'h0000_0102, 1'b0);
    mem_op("lbu", 32'h0000_0101, 32'd0, 3'd4, 1'b1, 1'b0, 5'd9, 1'b1, 32'h1234_F600, 1,
           4'b0010, 32'd0, 32'h0000_00F6, 1'b1);
    mem_op("lh", 32'h0000_0102, 32'd0, 3'd1, 1'b1, 1'b0, 5'd10, 1'b1, 32'h8001_0000, 0,
           4'b1100, 32'd0, 32'hFFFF_8001, 1'b1);
    mem_op("lhu", 32'h0000_0100, 32'd0, 3'd5, 1'b1, 1'b0, 5'd11, 1'b1, 32'h1234_9ABC, 0,
           4'b0011, 32'd0, 32'h0000_9ABC, 1'b1);
    mem_op("lw", 32'h0000_0200, 32'd0, 3'd2, 1'b1, 1'b0, 5'd3, 1'b1, 32'hDEAD_BEEF, 3,
           4'b1111, 32'd0, 32'hDEAD_BEEF, 1'b1);
    mem_op("sb", 32'h0000_0201, 32'h1122_3344, 3'd0, 1'b0, 1'b1, 5'd4, 1'b1, 32'd0, 0,
           4'b0010, 32'h4444_4444, 32'h0000_0201, 1'b0);
    mem_op("sw", 32'h0000_0300, 32'hCAFE_F00D, 3'd2, 1'b0, 1'b1, 5'd4, 1'b0, 32'd0, 1,
           4'b1111, 32'hCAFE_F00D, 32'h0000_0300, 1'b0);
    mem_op("lw_rd0", 32'h0000_0400, 32'd0, 3'd2, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0001, 0,
           4'b1111, 32'd0, 32'h0000_0001, 1'b0);
    mem_op("both_en", 32'h0000_0500, 32'h0102_0304, 3'd2, 1'b1, 1'b1, 5'd6, 1'b1, 32'd0, 0,
           4'b1111, 32'h0102_0304, 32'h0000_0500, 1'b0);
    mem_op("size3_w", 32'h0000_0600, 32'd0, 3'd3, 1'b1, 1'b0, 5'd13, 1'b1, 32'h8765_4321, 0,
           4'b1111, 32'd0, 32'h8765_4321, 1'b1);
    mem_op("size6_w", 32'h0000_0604, 32'd0, 3'd6, 1'b1, 1'b0, 5'd14, 1'b1, 32'hF000_000F, 0,
           4'b1111, 32'd0, 32'hF000_000F, 1'b1);
  endtask

  task automatic test_timeout();
    int cnt;
    valid_in         = 1'b1;
    alu_res          = 32'h0000_0040;
    mem_size         = 3'd2;
    mem_read_enable  = 1'b1;
    rd_idx           = 5'd9;
    reg_write_enable = 1'b1;
    sb.push_back('{32'd0, 5'd9, 1'b0, 1'b1, 1'b0});
    tick();
    idle_inputs();
    cnt = 0;
    while (stall_out && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("timeout_cycles", cnt, 32'd16);
    chk("timeout_err", {29'd0, bus_err_out, valid_out, dmem_req}, 32'd6);
    tick();
    chk("timeout_err_pulse", {30'd0, bus_err_out, valid_out}, 32'd0);
  endtask

  task automatic test_reset_in_req();
    valid_in        = 1'b1;
    alu_res         = 32'h0000_0080;
    mem_size        = 3'd2;
    mem_read_enable = 1'b1;
    rd_idx          = 5'd2;
    reg_write_enable = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("rst_req_before", {31'd0, stall_out}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_req_after", {29'd0, dmem_req, valid_out, stall_out}, 32'd0);
    repeat (2) tick();
    chk("rst_req_no_wb", {31'd0, valid_out}, 32'd0);
  endtask

  task automatic test_back_to_back();
    valid_in         = 1'b1;
    alu_res          = 32'h0000_0010;
    mem_size         = 3'd2;
    mem_read_enable  = 1'b1;
    rd_idx           = 5'd4;
    reg_write_enable = 1'b1;
    sb.push_back('{32'h0000_0042, 5'd4, 1'b1, 1'b0, 1'b1});
    tick();
    mem_read_enable = 1'b0;
    alu_res         = 32'h0000_0077;
    rd_idx          = 5'd6;
    sb.push_back('{32'h0000_0077, 5'd6, 1'b1, 1'b0, 1'b1});
    chk("b2b_stall", {31'd0, stall_out}, 32'd1);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0000_0042;
    tick();
    dmem_ready = 1'b0;
    chk("b2b_load_wb", wb_val, 32'h0000_0042);
    chk("b2b_load_ctl", {30'd0, valid_out, stall_out}, 32'd2);
    tick();
    idle_inputs();
    chk("b2b_alu_wb", wb_val, 32'h0000_0077);
    chk("b2b_alu_valid", {31'd0, valid_out}, 32'd1);
    tick();
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    valid_in         = 1'b1;
    alu_res          = 32'h0000_0101;
    mem_size         = 3'd2;
    mem_read_enable  = 1'b1;
    rd_idx           = 5'd7;
    reg_write_enable = 1'b1;
    sb.push_back('{32'd0, 5'd7, 1'b0, 1'b0, 1'b0});
    chk("mis_no_req_comb", {31'd0, dmem_req}, 32'd0);
    tick();
    idle_inputs();
    chk("mis_pulse", {28'd0, misaligned_out, valid_out, dmem_req, stall_out}, 32'd12);
    tick();
    chk("mis_clear", {29'd0, misaligned_out, valid_out, dmem_req}, 32'd0);
  endtask
`else
  task automatic test_misalign();
    mem_op("lh_odd", 32'h0000_0103, 32'd0, 3'd1, 1'b1, 1'b0, 5'd15, 1'b1, 32'hABCD_0000, 0,
           4'b1100, 32'd0, 32'hFFFF_ABCD, 1'b1);
    mem_op("lw_odd", 32'h0000_0101, 32'd0, 3'd2, 1'b1, 1'b0, 5'd16, 1'b1, 32'h1122_3344, 0,
           4'b1111, 32'd0, 32'h1122_3344, 1'b1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_loads_stores();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    test_misalign();
    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
